conv_tile_scheduler: RTL

- Sequences one convolution layer as an M x N x K grid of tiles through the systolic-array controller.
- Issues one start per tile and waits for completion over the controller's start/ready handshake.
- Presents the current tile indices and the accumulator clear/writeback qualifiers to the address generators and accumulator.
- Sits between the layer-config interface (host/DMA side) and the array controller.

---
 rtl/conv_tile_scheduler.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_tile_scheduler.sv
// -----------------------------------------------------------------------------
// conv_tile_scheduler
//
// Walks one convolution layer as an M x N x K grid of tiles and hands each
// tile to the systolic-array controller over a start/ready handshake. The walk
// order is K fastest, then N, then M. The current indices and the accumulator
// qualifiers stay stable for the whole lifetime of each tile so the address
// generators and the accumulator can use them directly.
//
// Optional feature (macro TILE_SCHED_PERF_EN):
//   Adds perf_busy_cycles / perf_stall_cycles. Both clear on config accept and
//   on reset, saturate at all-ones and hold after the layer completes. With
//   the macro undefined there are no extra ports and no counter logic.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   cfg_valid/cfg_ready  layer config handshake (accepted only while idle)
//   cfg_m/n/k_tiles      tile counts for the layer (unsigned, CNT_W bits)
//   ctrl_start           one-cycle start pulse to the array controller
//   ctrl_ready           controller idle level
//   tile_m/n/k           current tile indices
//   acc_clr              current tile is the first K tile
//   acc_wb               current tile is the last K tile
//   busy                 layer in progress
//   layer_done           one-cycle pulse when the layer completes
//   perf_busy_cycles     (optional) cycles with busy=1
//   perf_stall_cycles    (optional) cycles waiting in ISSUE with ctrl_ready=0
// -----------------------------------------------------------------------------
module conv_tile_scheduler #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_m_tiles,
    input  logic [CNT_W-1:0] cfg_n_tiles,
    input  logic [CNT_W-1:0] cfg_k_tiles,
    output logic             ctrl_start,
    input  logic             ctrl_ready,
    output logic [CNT_W-1:0] tile_m,
    output logic [CNT_W-1:0] tile_n,
    output logic [CNT_W-1:0] tile_k,
    output logic             acc_clr,
    output logic             acc_wb,
    output logic             busy,
    output logic             layer_done
`ifdef TILE_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_busy_cycles,
    output logic [31:0]      perf_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CntZero = '0;
    localparam logic [CNT_W-1:0] CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StWaitDone,
        StNext,
        StDone
    } state_e;

    state_e           state_q, state_d;

    // Counts latched at accept; all index compares use these, never cfg_*.
    logic [CNT_W-1:0] m_cnt_q, m_cnt_d;
    logic [CNT_W-1:0] n_cnt_q, n_cnt_d;
    logic [CNT_W-1:0] k_cnt_q, k_cnt_d;

    logic [CNT_W-1:0] tile_m_q, tile_m_d;
    logic [CNT_W-1:0] tile_n_q, tile_n_d;
    logic [CNT_W-1:0] tile_k_q, tile_k_d;

    logic             cfg_accept;
    logic             cfg_has_zero;
    logic             m_last;
    logic             n_last;
    logic             k_last;
    logic             layer_last;

    // -------------------------------------------------------------------------
    // Decode helpers
    // -------------------------------------------------------------------------
    assign cfg_accept   = (state_q == StIdle) && cfg_valid;
    assign cfg_has_zero = (cfg_m_tiles == CntZero) || (cfg_n_tiles == CntZero) ||
                          (cfg_k_tiles == CntZero);

    // Latched counts are never zero while tiles are being walked, so count-1
    // cannot underflow in the states where these matter.
    assign m_last     = (tile_m_q == (m_cnt_q - CntOne));
    assign n_last     = (tile_n_q == (n_cnt_q - CntOne));
    assign k_last     = (tile_k_q == (k_cnt_q - CntOne));
    assign layer_last = m_last && n_last && k_last;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            m_cnt_q  <= '0;
            n_cnt_q  <= '0;
            k_cnt_q  <= '0;
            tile_m_q <= '0;
            tile_n_q <= '0;
            tile_k_q <= '0;
        end else begin
            state_q  <= state_d;
            m_cnt_q  <= m_cnt_d;
            n_cnt_q  <= n_cnt_d;
            k_cnt_q  <= k_cnt_d;
            tile_m_q <= tile_m_d;
            tile_n_q <= tile_n_d;
            tile_k_q <= tile_k_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, index walk and start pulse
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        m_cnt_d    = m_cnt_q;
        n_cnt_d    = n_cnt_q;
        k_cnt_d    = k_cnt_q;
        tile_m_d   = tile_m_q;
        tile_n_d   = tile_n_q;
        tile_k_d   = tile_k_q;
        ctrl_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    m_cnt_d  = cfg_m_tiles;
                    n_cnt_d  = cfg_n_tiles;
                    k_cnt_d  = cfg_k_tiles;
                    tile_m_d = '0;
                    tile_n_d = '0;
                    tile_k_d = '0;
                    // An empty grid still completes with a done pulse.
                    state_d  = cfg_has_zero ? StDone : StIssue;
                end
            end

            StIssue: begin
                // Start only when the controller is idle; otherwise stall here.
                if (ctrl_ready) begin
                    ctrl_start = 1'b1;
                    state_d    = StWaitAck;
                end
            end

            StWaitAck: begin
                // Controller drops ready once it has taken the tile.
                if (!ctrl_ready) begin
                    state_d = StWaitDone;
                end
            end

            StWaitDone: begin
                if (ctrl_ready) begin
                    state_d = StNext;
                end
            end

            StNext: begin
                if (layer_last) begin
                    // Indices left on the final tile.
                    state_d = StDone;
                end else begin
                    state_d = StIssue;
                    if (!k_last) begin
                        tile_k_d = tile_k_q + CntOne;
                    end else begin
                        tile_k_d = '0;
                        if (!n_last) begin
                            tile_n_d = tile_n_q + CntOne;
                        end else begin
                            tile_n_d = '0;
                            tile_m_d = tile_m_q + CntOne;
                        end
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy       = (state_q != StIdle);
    assign cfg_ready  = !busy;
    assign layer_done = (state_q == StDone);
    assign tile_m     = tile_m_q;
    assign tile_n     = tile_n_q;
    assign tile_k     = tile_k_q;
    assign acc_clr    = busy && (tile_k_q == CntZero);
    assign acc_wb     = busy && k_last;

`ifdef TILE_SCHED_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;
    logic        stall_cycle;

    assign stall_cycle = (state_q == StIssue) && !ctrl_ready;

    always_ff @(posedge clk) begin
        if (rst || cfg_accept) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (stall_cycle && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`else
    // Accept decode only feeds the optional counters.
    logic unused_cfg_accept;
    assign unused_cfg_accept = cfg_accept;
`endif

endmodule
